ts_sync_scheduler: RTL and testbench
====================================

# ts_sync_scheduler

Sequences the chip timestamp clock and the injection pattern-generator sync in the `timestamp_int_clk` domain. On a run request it:
- pulses the chip reset for a fixed hold time;
- starts a glitch-free divide-by-2 timestamp clock;
- keeps a mirror timestamp counter.

It issues a stretched sync pulse to the pattern generator's `syncrst` input when the counter reaches a programmed value or overflows, so injections land at known timestamps. It sits between the FTDI configuration block (clk domain) and the `timestamp_clk` pin, `res_n` gating and `sync_async_patgen`.

## Interface
Parameters:
- `TS_WIDTH`, 10 — width of the mirror timestamp counter, which matches the chip timestamp width.
- `RES_HOLD`, 16 — number of `timestamp_int_clk` cycles `chip_res_n` is held low in RESET; must be ≥ 1.
- `STRETCH`, 4 — length in cycles of the `inj_sync` pulse, sized for capture by the 100 MHz clk domain; must be ≥ 1.

Ports:
- `timestamp_int_clk`  in  1  block clock.
- `cpu_resetn`  in  1  reset: asynchronous, active-low.
- `run_req`  in  1  level from clk domain; synchronised internally by a 2-FF synchroniser.
- `sync_on_overflow`  in  1  quasi-static; 1 selects an overflow-triggered sync.
- `trigger_ts`  in  TS_WIDTH  quasi-static compare value; latched on IDLE→RESET.
- `ts_clk_out`  out  1  gated divide-by-2 timestamp clock (registered).
- `chip_res_n`  out  1  chip reset request; ANDed externally with the config `res_n`.
- `ts_count`  out  TS_WIDTH  mirror timestamp counter.
- `ts_overflow`  out  1  one-cycle pulse on counter wrap.
- `inj_sync`  out  1  stretched sync pulse to the pattern generator.
- `state`  out  2  encoded FSM state, for debug/LED.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
States (encodings): IDLE=0, RESET=1, RUN=2, STOP=3.

- **IDLE.** `ts_clk_out`=0, counter frozen, `chip_res_n` holds its last value.
  - `run_req_s`=1 → RESET. On this transition `trigger_ts` is latched, `ts_count` is cleared, and the hold counter is loaded with `RES_HOLD`-1.
- **RESET.** `chip_res_n`=0, `ts_clk_out`=0.
  - The hold counter decrements each cycle; at 0 → RUN, with `chip_res_n`=1 from that transition onward.
  - `run_req_s` dropping in RESET → IDLE immediately, with `chip_res_n` left at 0.
- **RUN.** `ts_clk_out` toggles every cycle; the first toggle is 0→1 on the first RUN cycle.
  - On each 1→0 transition of `ts_clk_out`, `ts_count` increments. The wrap from 2^TS_WIDTH−1 to 0 is allowed and raises `ts_overflow` for that one cycle.
  - `run_req_s`=0 with `ts_clk_out`=1 → STOP.
  - `run_req_s`=0 with `ts_clk_out`=0 → IDLE.
- **STOP.** Drives `ts_clk_out` to 0 for one cycle and does not increment `ts_count`, then → IDLE. This guarantees no runt high phase.

Sync generation:
- Trigger event (RUN only): the cycle in which `ts_count` takes the value of latched `trigger_ts`. If `sync_on_overflow`=1, the trigger event is instead the wrap cycle.
- `trigger_ts`=0 fires on the first increment cycle that reaches 0, i.e. at the wrap. Entry into RUN does not fire it.
- On a trigger event the stretch counter loads `STRETCH`; `inj_sync` = (stretch counter ≠ 0).
- A new trigger during an active stretch reloads the counter, so the pulse is extended, not doubled.
- The stretch continues to expire even after the block leaves RUN.
- `busy` = (state ≠ IDLE).

Reset behaviour:
- `cpu_resetn` low, asynchronously: state=IDLE, `ts_clk_out`=0, `chip_res_n`=0, `ts_count`=0, `ts_overflow`=0, `inj_sync`=0, stretch counter=0, synchroniser flops=0, latched trigger=0.
- Reset asserted mid-RUN stops the clock low immediately. This is the only permitted runt.

## Timing
- `run_req` to `busy`: 3 cycles (2 synchroniser stages + state register).
- `chip_res_n` low for exactly `RES_HOLD` cycles. The first `ts_clk_out` rise is in the cycle after `chip_res_n` rises.
- `ts_clk_out` period is 2 cycles with 50% duty. `ts_count` changes on the cycle `ts_clk_out` falls, giving one increment per 2 cycles.
- `inj_sync` asserts in the same cycle `ts_count` reaches the trigger value (registered together) and stays high for `STRETCH` cycles.
- `run_req` deassert to IDLE: 3 or 4 cycles depending on the clock phase.

## Structure
- Shared package `ts_sync_pkg` holds:
  - the state encoding constants (IDLE/RESET/RUN/STOP);
  - the default `TS_WIDTH`.
- One natural sub-module, `sync_2ff`: a generic 2-FF level synchroniser with async reset to 0, reused for `run_req`.
- Everything else is in a single module: FSM, hold counter, divider, mirror counter, stretch counter.

## Test plan
All scenarios use `TS_WIDTH`=10, `RES_HOLD`=16, `STRETCH`=4.
- Reset then idle: `cpu_resetn`=0 then 1, `run_req`=0 → all outputs 0, state=0, for 100 cycles.
- Start sequence: `run_req`↑ → `busy` at cycle 3; `chip_res_n` low 16 cycles; first `ts_clk_out` rise in the next cycle; `ts_count`=5 after 10 RUN cycles.
- Compare trigger: `trigger_ts`=7, `sync_on_overflow`=0 → `inj_sync` high exactly 4 cycles starting when `ts_count` becomes 7; no second pulse until the count reaches 7 again after wrap (2048 cycles later).
- Overflow trigger: `sync_on_overflow`=1 → `ts_overflow` and `inj_sync` rise together when the count wraps 1023→0; `ts_overflow` lasts 1 cycle, `inj_sync` 4 cycles.
- Stop on both phases: drop `run_req` while `ts_clk_out`=1 and separately while it is 0 → clock ends low with no high phase shorter than 1 cycle; `ts_count` frozen; state=0.
- Reset mid-RUN and request drop in RESET: assert `cpu_resetn`=0 while `ts_count`=300 → all outputs 0 asynchronously. Separately, drop `run_req` at hold cycle 5 → IDLE with `chip_res_n`=0 and no `ts_clk_out` edges.

Source files
------------

// File: rtl/ts_sync_pkg.sv
// Shared definitions for the timestamp sync scheduler: FSM state
// encoding and the default mirror-counter width.
package ts_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    localparam int TS_WIDTH_DEF = 10;

endpackage

// File: rtl/sync_2ff.sv
// Generic 2-FF level synchroniser, async active-low reset to 0.
// Ports: clk, rst_n, d (async level in), q (synchronised level out).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ts_sync_scheduler.sv
// Sequences chip reset, a glitch-free div-2 timestamp clock, a mirror
// timestamp counter and a stretched pattern-generator sync pulse.
// Ports: timestamp_int_clk/cpu_resetn (clock, async active-low reset);
//   run_req (async level), sync_on_overflow, trigger_ts (quasi-static);
//   ts_clk_out, chip_res_n, ts_count, ts_overflow, inj_sync, state, busy.
module ts_sync_scheduler
    import ts_sync_pkg::*;
#(
    parameter int TS_WIDTH = TS_WIDTH_DEF,
    parameter int RES_HOLD = 16,
    parameter int STRETCH  = 4
) (
    input  logic                timestamp_int_clk,
    input  logic                cpu_resetn,
    input  logic                run_req,
    input  logic                sync_on_overflow,
    input  logic [TS_WIDTH-1:0] trigger_ts,
    output logic                ts_clk_out,
    output logic                chip_res_n,
    output logic [TS_WIDTH-1:0] ts_count,
    output logic                ts_overflow,
    output logic                inj_sync,
    output logic [1:0]          state,
    output logic                busy
);

    localparam int HW = (RES_HOLD > 1) ? $clog2(RES_HOLD) : 1;
    localparam int SW = $clog2(STRETCH + 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(RES_HOLD - 1);
    localparam logic [SW-1:0] STR_INIT  = SW'(STRETCH);

    logic                run_req_s;
    state_e              state_q, state_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic                ts_clk_q, ts_clk_d;
    logic                chip_res_n_q, chip_res_n_d;
    logic [TS_WIDTH-1:0] count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [SW-1:0]       stretch_q, stretch_d;
    logic [TS_WIDTH-1:0] trig_q, trig_d;

    logic                inc;
    logic                wrap;
    logic                fire;
    logic [TS_WIDTH-1:0] count_inc;

    sync_2ff u_run_sync (
        .clk   (timestamp_int_clk),
        .rst_n (cpu_resetn),
        .d     (run_req),
        .q     (run_req_s)
    );

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        ts_clk_d     = 1'b0;
        chip_res_n_d = chip_res_n_q;
        count_d      = count_q;
        trig_d       = trig_q;
        inc          = 1'b0;
        count_inc    = count_q + TS_WIDTH'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (run_req_s) begin
                    state_d      = ST_RESET;
                    trig_d       = trigger_ts;
                    count_d      = '0;
                    hold_d       = HOLD_INIT;
                    chip_res_n_d = 1'b0;
                end
            end
            ST_RESET: begin
                chip_res_n_d = 1'b0;
                if (!run_req_s) begin
                    state_d = ST_IDLE;
                end else if (hold_q == '0) begin
                    state_d      = ST_RUN;
                    chip_res_n_d = 1'b1;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            ST_RUN: begin
                if (!run_req_s) begin
                    // A high phase must finish via STOP so it is never cut short.
                    state_d = ts_clk_q ? ST_STOP : ST_IDLE;
                end else begin
                    ts_clk_d = ~ts_clk_q;
                    inc      = ts_clk_q;
                end
            end
            ST_STOP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (inc) begin
            count_d = count_inc;
        end

        wrap  = inc & (&count_q);
        ovf_d = wrap;
        fire  = inc & (sync_on_overflow ? wrap : (count_inc == trig_q));

        // Retrigger reloads, so overlapping syncs merge into one longer pulse.
        if (fire) begin
            stretch_d = STR_INIT;
        end else if (stretch_q != '0) begin
            stretch_d = stretch_q - SW'(1);
        end else begin
            stretch_d = stretch_q;
        end
    end

    always_ff @(posedge timestamp_int_clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            ts_clk_q     <= 1'b0;
            chip_res_n_q <= 1'b0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            stretch_q    <= '0;
            trig_q       <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            ts_clk_q     <= ts_clk_d;
            chip_res_n_q <= chip_res_n_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            stretch_q    <= stretch_d;
            trig_q       <= trig_d;
        end
    end

    assign ts_clk_out  = ts_clk_q;
    assign chip_res_n  = chip_res_n_q;
    assign ts_count    = count_q;
    assign ts_overflow = ovf_q;
    assign inj_sync    = (stretch_q != '0);
    assign state       = state_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ts_sync_scheduler.sv
// Self-checking bench for ts_sync_scheduler: table-driven start sequence,
// directed corner sequences and randomized runs against a reference model.
module tb_ts_sync_scheduler;

    localparam int W  = 10;
    localparam int RH = 16;
    localparam int ST = 4;
    localparam int M  = 1 << W;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         run_req = 1'b0;
    logic         sov = 1'b0;
    logic [W-1:0] trig = '0;

    logic         ts_clk_out;
    logic         chip_res_n;
    logic [W-1:0] ts_count;
    logic         ts_overflow;
    logic         inj_sync;
    logic [1:0]   state;
    logic         busy;

    ts_sync_scheduler #(
        .TS_WIDTH (W),
        .RES_HOLD (RH),
        .STRETCH  (ST)
    ) dut (
        .timestamp_int_clk (clk),
        .cpu_resetn        (rstn),
        .run_req           (run_req),
        .sync_on_overflow  (sov),
        .trigger_ts        (trig),
        .ts_clk_out        (ts_clk_out),
        .chip_res_n        (chip_res_n),
        .ts_count          (ts_count),
        .ts_overflow       (ts_overflow),
        .inj_sync          (inj_sync),
        .state             (state),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode 0 idle, 1 reset, 2 run, 3 stop.
    // Timestamp state is derived from the number of RUN cycles elapsed.
    int m_mode   = 0;
    int m_hold   = 0;
    int m_runlen = 0;
    int m_trig   = 0;
    int m_fire   = -1;
    int m_cyc    = 0;
    bit m_chip   = 1'b0;
    bit m_ovf    = 1'b0;
    bit rq_line[$];

    function automatic int m_count();
        return (m_runlen / 2) % M;
    endfunction

    function automatic void model_reset();
        m_mode   = 0;
        m_hold   = 0;
        m_runlen = 0;
        m_trig   = 0;
        m_fire   = -1;
        m_chip   = 1'b0;
        m_ovf    = 1'b0;
        rq_line  = {1'b0, 1'b0};
    endfunction

    function automatic void model_edge();
        bit s;
        int c;
        bit w;
        m_cyc++;
        s = rq_line.pop_front();
        rq_line.push_back(run_req);
        m_ovf = 1'b0;
        case (m_mode)
            0: begin
                if (s) begin
                    m_mode   = 1;
                    m_hold   = RH;
                    m_trig   = int'(trig);
                    m_runlen = 0;
                    m_chip   = 1'b0;
                end
            end
            1: begin
                if (!s) begin
                    m_mode = 0;
                end else begin
                    m_hold--;
                    if (m_hold == 0) begin
                        m_mode = 2;
                        m_chip = 1'b1;
                    end
                end
            end
            2: begin
                if (!s) begin
                    m_mode = (m_runlen % 2 == 1) ? 3 : 0;
                end else begin
                    m_runlen++;
                    if (m_runlen % 2 == 0) begin
                        c = m_count();
                        w = (c == 0);
                        m_ovf = w;
                        if (sov ? w : (c == m_trig)) m_fire = m_cyc;
                    end
                end
            end
            default: m_mode = 0;
        endcase
    endfunction

    function automatic logic [16:0] model_vec();
        logic [1:0]   s;
        logic         c;
        logic         inj;
        logic [W-1:0] cnt;
        s   = 2'(m_mode);
        c   = (m_mode == 2) && (m_runlen % 2 == 1);
        inj = (m_fire >= 0) && (m_cyc - m_fire < ST);
        cnt = W'(m_count());
        return {s, (m_mode != 0), m_chip, c, m_ovf, inj, cnt};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {state, busy, chip_res_n, ts_clk_out,
                ts_overflow, inj_sync, ts_count};
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check($sformatf("cycle%0d", m_cyc), 32'(dut_vec()), 32'(model_vec()));
    endtask

    typedef struct {
        int           k;
        logic [1:0]   st;
        logic         bsy;
        logic         chip;
        logic         tclk;
        logic [W-1:0] cnt;
        logic         inj;
    } vec_t;

    vec_t tbl[13];

    task automatic stop_phase(input bit ph);
        int n;
        int frozen;
        run_req = 1'b1;
        n = 0;
        while (!(state == 2'd2 && ts_clk_out == ph && ts_count >= 2) && n < 300) begin
            step();
            n++;
        end
        check($sformatf("stop%0d_reach", ph), 32'(n < 300), 32'd1);
        run_req = 1'b0;
        step();
        step();
        frozen = m_count();
        step();
        check($sformatf("stop%0d_state", ph), 32'(state), ph ? 32'd3 : 32'd0);
        check($sformatf("stop%0d_clk", ph), 32'(ts_clk_out), 32'd0);
        n = 3;
        while (busy && n < 8) begin
            step();
            n++;
        end
        check($sformatf("stop%0d_latency", ph), 32'(n), ph ? 32'd4 : 32'd3);
        check($sformatf("stop%0d_frozen", ph), 32'(ts_count), 32'(frozen));
    endtask

    initial begin
        int k;
        int bad;
        int n;
        int rises;
        int hi;

        model_reset();
        tbl[0]  = '{2,  2'd0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0};
        tbl[1]  = '{3,  2'd1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0};
        tbl[2]  = '{18, 2'd1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0};
        tbl[3]  = '{19, 2'd2, 1'b1, 1'b1, 1'b0, 10'd0, 1'b0};
        tbl[4]  = '{20, 2'd2, 1'b1, 1'b1, 1'b1, 10'd0, 1'b0};
        tbl[5]  = '{21, 2'd2, 1'b1, 1'b1, 1'b0, 10'd1, 1'b0};
        tbl[6]  = '{28, 2'd2, 1'b1, 1'b1, 1'b1, 10'd4, 1'b0};
        tbl[7]  = '{29, 2'd2, 1'b1, 1'b1, 1'b0, 10'd5, 1'b0};
        tbl[8]  = '{32, 2'd2, 1'b1, 1'b1, 1'b1, 10'd6, 1'b0};
        tbl[9]  = '{33, 2'd2, 1'b1, 1'b1, 1'b0, 10'd7, 1'b1};
        tbl[10] = '{35, 2'd2, 1'b1, 1'b1, 1'b0, 10'd8, 1'b1};
        tbl[11] = '{36, 2'd2, 1'b1, 1'b1, 1'b1, 10'd8, 1'b1};
        tbl[12] = '{37, 2'd2, 1'b1, 1'b1, 1'b0, 10'd9, 1'b0};

        // Reset, then 100 idle cycles with everything low.
        repeat (3) @(negedge clk);
        check("reset_state", 32'(dut_vec()), 32'd0);
        rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (dut_vec() != '0) bad++;
        end
        check("idle100", 32'(bad), 32'd0);

        // Start sequence and compare trigger at 7.
        trig    = 10'd7;
        sov     = 1'b0;
        run_req = 1'b1;
        k = 0;
        for (int i = 0; i < 13; i++) begin
            while (k < tbl[i].k) begin
                step();
                k++;
            end
            check($sformatf("tbl_k%0d", tbl[i].k), 32'(dut_vec()),
                  32'({tbl[i].st, tbl[i].bsy, tbl[i].chip, tbl[i].tclk,
                       1'b0, tbl[i].inj, tbl[i].cnt}));
        end

        // No second pulse until the count returns to 7 after the wrap.
        bad = 0;
        while (k < 2081) begin
            step();
            k++;
            if (k < 2081 && inj_sync) bad++;
            if (k == 2067) begin
                check("wrap_ovf", 32'(ts_overflow), 32'd1);
                check("wrap_cnt", 32'(ts_count), 32'd0);
            end
            if (k == 2068) check("wrap_ovf_end", 32'(ts_overflow), 32'd0);
        end
        check("no_extra_sync", 32'(bad), 32'd0);
        check("second_sync", 32'({inj_sync, ts_count}), 32'({1'b1, 10'd7}));

        // Stop from both clock phases.
        run_req = 1'b0;
        repeat (5) step();
        stop_phase(1'b0);
        stop_phase(1'b1);

        // Request drop during the reset hold.
        run_req = 1'b1;
        repeat (7) step();
        check("hold_in_reset", 32'(state), 32'd1);
        run_req = 1'b0;
        rises = 0;
        repeat (6) begin
            step();
            if (ts_clk_out) rises++;
        end
        check("hold_drop_state", 32'(state), 32'd0);
        check("hold_drop_chip", 32'(chip_res_n), 32'd0);
        check("hold_drop_clk", 32'(rises), 32'd0);

        // Overflow-triggered sync.
        sov     = 1'b1;
        trig    = 10'd5;
        run_req = 1'b1;
        n = 0;
        while (!ts_overflow && n < 2300) begin
            step();
            n++;
        end
        check("ovf_seen", 32'(n < 2300), 32'd1);
        check("ovf_sync", 32'({inj_sync, ts_count}), 32'({1'b1, 10'd0}));
        hi = 1;
        step();
        check("ovf_1cycle", 32'(ts_overflow), 32'd0);
        while (inj_sync && hi < 10) begin
            hi++;
            step();
        end
        check("ovf_stretch", 32'(hi), 32'(ST));

        // Async reset in RUN with the clock high.
        n = 0;
        while (!(m_mode == 2 && m_count() == 300 && m_runlen % 2 == 1) && n < 2000) begin
            step();
            n++;
        end
        check("reach300", 32'({ts_clk_out, ts_count}), 32'({1'b1, 10'd300}));
        #1 rstn = 1'b0;
        #1 check("async_rst", 32'(dut_vec()), 32'd0);
        model_reset();
        run_req = 1'b0;
        sov     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("in_reset", 32'(dut_vec()), 32'd0);
        rstn = 1'b1;

        // Randomized runs against the model.
        for (int it = 0; it < 40; it++) begin
            int len;
            run_req = 1'b0;
            repeat (4) step();
            sov = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: trig = '0;
                1: trig = '1;
                default: trig = W'($urandom_range(1, 60));
            endcase
            if (it % 13 == 5) len = 2120;
            else if ($urandom_range(0, 3) == 0) len = $urandom_range(3, 22);
            else len = $urandom_range(25, 300);
            run_req = 1'b1;
            for (int j = 0; j < len; j++) begin
                step();
                if ($urandom_range(0, 199) == 0) begin
                    run_req = 1'b0;
                    step();
                    run_req = 1'b1;
                end
            end
        end
        run_req = 1'b0;
        repeat (8) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
